// File: rtl/add_pkg.sv
// Shared defaults, FSM state type and the 4-bit carry-lookahead helper
// used by the slice-serial add/sub scheduler.
package add_pkg;

  localparam int unsigned DEF_WIDTH  = 64;
  localparam int unsigned DEF_SLICE  = 16;
  localparam int unsigned DEF_NSLICE = DEF_WIDTH / DEF_SLICE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {cout, sum[3:0]}; all group carries come straight from g/p/cin.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/adder16c.sv
// Combinational W-bit adder with carry in/out, built from 4-bit
// carry-lookahead groups chained group to group (four groups at W=16).
module adder16c
  import add_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W-1:0] s;
  logic         c;
  logic [4:0]   r;

  always_comb begin
    s = '0;
    c = cin_i;
    r = '0;
    for (int unsigned g = 0; g < W / 4; g++) begin
      r           = cla4(a_i[g*4 +: 4], b_i[g*4 +: 4], c);
      s[g*4 +: 4] = r[3:0];
      c           = r[4];
    end
  end

  assign sum_o  = s;
  assign cout_o = c;

endmodule

// File: rtl/add_sched.sv
// Two-requester round-robin add/sub unit: one operation at a time is pushed
// slice by slice through a single shared SLICE-bit adder.
module add_sched
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sub_q;
  logic             id_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             last_q;

  logic             gnt0;
  logic             gnt1;
  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] s_sl;
  logic             c_sl;

  // last_q names the requester granted most recently; a tie goes to the other one.
  always_comb begin
    gnt0 = (state_q == IDLE) && !rst && req0_valid && (!req1_valid || last_q);
    gnt1 = (state_q == IDLE) && !rst && req1_valid && (!req0_valid || !last_q);
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    a_sl = a_q[k_q*SLICE +: SLICE];
    b_sl = b_q[k_q*SLICE +: SLICE] ^ {SLICE{sub_q}};
  end

  adder16c #(
    .W (SLICE)
  ) u_adder (
    .a_i    (a_sl),
    .b_i    (b_sl),
    .cin_i  (carry_q),
    .sum_o  (s_sl),
    .cout_o (c_sl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt0 || gnt1) begin
            a_q     <= gnt1 ? req1_a : req0_a;
            b_q     <= gnt1 ? req1_b : req0_b;
            sub_q   <= gnt1 ? req1_sub : req0_sub;
            carry_q <= gnt1 ? req1_sub : req0_sub;
            id_q    <= gnt1;
            last_q  <= gnt1;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q[k_q*SLICE +: SLICE] <= s_sl;
          carry_q                   <= c_sl;
          if (k_q == KW'(NSLICE - 1)) begin
            cout_q  <= c_sl;
            k_q     <= '0;
            state_q <= DONE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_add_sched.sv
// Scoreboard bench for add_sched: driver issues operations, a negedge monitor
// predicts grants/latency/results from plain arithmetic and compares.
module tb_add_sched;

  localparam int unsigned W   = 64;
  localparam int          LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout, rsp_id, busy;

  always #5 clk = ~clk;

  add_sched #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
    .rsp_id(rsp_id), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         id;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   gnt_log[$];
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, acc0 = 0, acc1 = 0, acc_cyc = 0, hs_cyc = 0;
  bit   m_last = 1'b1;

  function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endfunction

  function automatic void fail_timeout(string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endfunction

  // Reference: round-robin grant, one op in flight, result LAT cycles after acceptance.
  always @(negedge clk) begin
    bit           e0, e1, ev;
    exp_t         x;
    logic [W-1:0] a, b;
    logic         s;
    cyc++;
    if (rst) begin
      chk("ready0_rst", W'(req0_ready), W'(0));
      chk("ready1_rst", W'(req1_ready), W'(0));
      sb.delete();
      m_last = 1'b1;
    end else begin
      e0 = (sb.size() == 0) && req0_valid && (!req1_valid || m_last);
      e1 = (sb.size() == 0) && req1_valid && (!req0_valid || !m_last);
      chk("ready0", W'(req0_ready), W'(e0));
      chk("ready1", W'(req1_ready), W'(e1));
      chk("busy", W'(busy), W'(sb.size() != 0));
      ev = (sb.size() != 0) && (cyc >= sb[0].due);
      chk("rsp_valid", W'(rsp_valid), W'(ev));
      if (ev) begin
        chk("rsp_sum", rsp_sum, sb[0].sum);
        chk("rsp_cout", W'(rsp_cout), W'(sb[0].cout));
        chk("rsp_id", W'(rsp_id), W'(sb[0].id));
        if (rsp_ready) begin
          void'(sb.pop_front());
          hs_cyc = cyc;
        end
      end
      if (e0 || e1) begin
        a = e1 ? req1_a : req0_a;
        b = e1 ? req1_b : req0_b;
        s = e1 ? req1_sub : req0_sub;
        if (!s) begin
          {x.cout, x.sum} = {1'b0, a} + {1'b0, b};
        end else begin
          x.sum  = a - b;
          x.cout = (a >= b);
        end
        x.id  = e1;
        x.due = cyc + LAT;
        sb.push_back(x);
        gnt_log.push_back(int'(e1));
        m_last  = e1;
        acc_cyc = cyc;
        if (e1) acc1++;
        else    acc0++;
      end
    end
  end

  task automatic set_req(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (r == 0) begin
      req0_a = a; req0_b = b; req0_sub = s; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_sub = s; req1_valid = 1'b1;
    end
  endtask

  task automatic wait_acc(input int r);
    int base;
    base = (r == 0) ? acc0 : acc1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (((r == 0) ? acc0 : acc1) != base) return;
    end
    fail_timeout("accept");
  endtask

  task automatic issue(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    set_req(r, a, b, s);
    wait_acc(r);
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (sb.size() == 0) return;
      @(posedge clk); #1;
    end
    fail_timeout("drain");
  endtask

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int tot, p0, p1, left0, left1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", W'(rsp_valid), W'(0));
    chk("reset_rsp_sum", rsp_sum, W'(0));
    chk("reset_rsp_cout", W'(rsp_cout), W'(0));
    chk("reset_rsp_id", W'(rsp_id), W'(0));
    chk("reset_busy", W'(busy), W'(0));

    issue(0, 64'h0000_0000_0000_FFFF, 64'd1, 1'b0);
    wait_idle();
    issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_idle();
    issue(0, 64'd5, 64'd7, 1'b1);
    wait_idle();
    issue(1, 64'd7, 64'd5, 1'b1);
    wait_idle();

    // Both requesters held valid for four operations.
    gnt_log.delete();
    set_req(0, rnd64(), rnd64(), 1'($urandom));
    set_req(1, rnd64(), rnd64(), 1'($urandom));
    p0 = acc0; p1 = acc1;
    for (int i = 0; i < 400 && (acc0 + acc1 - p0 - p1) < 4; i++) begin
      @(posedge clk); #1;
      if (acc0 != p0 && (acc0 + acc1 - p0 - p1) < 4) begin
        req0_a = rnd64(); req0_b = rnd64(); req0_sub = 1'($urandom);
      end
      if (acc1 != p1 && (acc0 + acc1 - p0 - p1) < 4) begin
        req1_a = rnd64(); req1_b = rnd64(); req1_sub = 1'($urandom);
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_idle();
    if (gnt_log.size() != 4) fail_timeout("tie_grants");
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      chk("tie_grant_order", W'(gnt_log[i]), W'(i % 2));

    // Back-pressure: hold rsp_ready low through three DONE cycles.
    rsp_ready = 1'b0;
    issue(1, rnd64(), rnd64(), 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    chk("bp_busy", W'(busy), W'(1));
    chk("bp_valid", W'(rsp_valid), W'(1));
    set_req(0, rnd64(), rnd64(), 1'b1);
    rsp_ready = 1'b1;
    wait_acc(0);
    req0_valid = 1'b0;
    chk("accept_after_handshake", W'(acc_cyc), W'(hs_cyc + 1));
    wait_idle();

    // Reset in the second RUN cycle discards the operation.
    issue(0, rnd64(), rnd64(), 1'b0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("post_rst_busy", W'(busy), W'(0));
    chk("post_rst_valid", W'(rsp_valid), W'(0));
    gnt_log.delete();
    set_req(0, 64'd100, 64'd23, 1'b0);
    set_req(1, 64'd1, 64'd2, 1'b1);
    wait_acc(0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (gnt_log.size() == 0) fail_timeout("post_rst_grant");
    else chk("post_rst_grant", W'(gnt_log[0]), W'(0));
    wait_idle();

    // Randomized traffic with random back-pressure.
    left0 = 20; left1 = 20;
    p0 = acc0; p1 = acc1;
    tot = 0;
    while ((left0 > 0 || left1 > 0 || req0_valid || req1_valid) && tot < 6000) begin
      rsp_ready = ($urandom % 4) != 0;
      if (req0_valid && acc0 != p0) begin req0_valid = 1'b0; left0--; end
      else if (!req0_valid && left0 > 0 && ($urandom % 2) == 1)
        set_req(0, rnd64(), rnd64(), 1'($urandom));
      if (req1_valid && acc1 != p1) begin req1_valid = 1'b0; left1--; end
      else if (!req1_valid && left1 > 0 && ($urandom % 2) == 1)
        set_req(1, rnd64(), rnd64(), 1'($urandom));
      p0 = acc0; p1 = acc1;
      @(posedge clk); #1;
      tot++;
    end
    if (tot >= 6000) fail_timeout("random_phase");
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
